tdm_demux: RTL and testbench

//  Receive end of a time-division-multiplexed (TDM) link, the inverse of the mux

---
 rtl/tdm_pkg.sv | 7 +
 rtl/tdm_slot_counter.sv | 28 ++
 rtl/tdm_demux.sv | 131 +++++++++++++
 tb/tb_tdm_demux.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared TDM link definitions: state encoding and default geometry used by both the mux and demux sides.
package tdm_pkg;
    localparam int unsigned TDM_W    = 8;
    localparam int unsigned TDM_N_CH = 4;

    typedef enum logic {HUNT, RUN} tdm_state_t;
endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-N_CH slot counter with increment, clear and load-to-1 controls; wrap flags the last slot.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int unsigned N_CH = TDM_N_CH,
    localparam int unsigned CW  = $clog2(N_CH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clear,
    input  logic          load1,
    output logic [CW-1:0] slot,
    output logic          wrap
);
    // Explicit compare so non-power-of-two frame lengths wrap correctly
    assign wrap = (slot == CW'(N_CH - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            slot <= '0;
        end else if (load1) begin
            slot <= CW'(1);
        end else if (inc) begin
            slot <= wrap ? '0 : slot + CW'(1);
        end
    end
endmodule

// File: rtl/tdm_demux.sv
// TDM receive demultiplexer: steers slot words into a frame and presents whole frames via valid/ready.
// Optional TDM_DEMUX_ERR_CNT_EN adds a saturating err_cnt port counting sync_err and ovf pulses.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int unsigned W    = TDM_W,
    parameter int unsigned N_CH = TDM_N_CH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            in_sof,
    input  logic [W-1:0]    in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N_CH*W-1:0] out_data,
    output logic            sync_err,
    output logic            ovf
`ifdef TDM_DEMUX_ERR_CNT_EN
    ,
    output logic [15:0]     err_cnt
`endif
);
    localparam int unsigned CW = $clog2(N_CH);

    tdm_state_t          state, state_next;
    logic [CW-1:0]       slot, wr_idx;
    logic                wrap;
    logic                cnt_inc, cnt_clr, cnt_ld1;
    logic                wr, done, sync_err_d, ovf_d, load;
    logic [N_CH*W-1:0]   fill, fill_next;

    tdm_slot_counter #(.N_CH(N_CH)) u_slot (
        .clk   (clk),
        .rst   (rst),
        .inc   (cnt_inc),
        .clear (cnt_clr),
        .load1 (cnt_ld1),
        .slot  (slot),
        .wrap  (wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= HUNT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            HUNT: if (in_valid && in_sof) state_next = RUN;
            RUN:  if (in_valid && !in_sof && slot == '0) state_next = HUNT;
            default: state_next = HUNT;
        endcase
    end

    always_comb begin
        wr         = 1'b0;
        wr_idx     = '0;
        cnt_inc    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_ld1    = 1'b0;
        sync_err_d = 1'b0;
        done       = 1'b0;
        case (state)
            HUNT: begin
                if (in_valid && in_sof) begin
                    wr      = 1'b1;
                    cnt_ld1 = 1'b1;
                end
            end
            RUN: begin
                if (in_valid) begin
                    if (in_sof) begin
                        // An early sof restarts the frame; stale slots get overwritten
                        wr         = 1'b1;
                        cnt_ld1    = 1'b1;
                        sync_err_d = (slot != '0);
                    end else if (slot == '0) begin
                        sync_err_d = 1'b1;
                        cnt_clr    = 1'b1;
                    end else begin
                        wr      = 1'b1;
                        wr_idx  = slot;
                        cnt_inc = 1'b1;
                        done    = wrap;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        fill_next = fill;
        if (wr) fill_next[wr_idx*W +: W] = in_data;
    end

    assign load  = done && (!out_valid || out_ready);
    assign ovf_d = done && out_valid && !out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            fill      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            fill     <= fill_next;
            sync_err <= sync_err_d;
            ovf      <= ovf_d;
            if (load) begin
                out_data  <= fill_next;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef TDM_DEMUX_ERR_CNT_EN
    logic [16:0] err_sum;
    assign err_sum = {1'b0, err_cnt} + 17'(sync_err_d) + 17'(ovf_d);

    always_ff @(posedge clk) begin
        if (rst) err_cnt <= '0;
        else     err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
`endif
endmodule

// File: tb/tb_tdm_demux.sv
// Directed self-checking bench for tdm_demux (W=8, N_CH=4); checks err_cnt when TDM_DEMUX_ERR_CNT_EN is defined.
module tb_tdm_demux;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_sof;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        sync_err;
    logic        ovf;
`ifdef TDM_DEMUX_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    int unsigned tests = 0;
    int unsigned fails = 0;

    tdm_demux #(.W(8), .N_CH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sync_err  (sync_err),
        .ovf       (ovf)
`ifdef TDM_DEMUX_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic sof, input logic [7:0] d);
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; out_ready = 1'b1;
        tick(); tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'h0);
        check("rst_sync", 32'(sync_err), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        // Basic frame
        send(1'b1, 8'h11); send(1'b0, 8'h22); send(1'b0, 8'h33);
        check("pre_last_valid", 32'(out_valid), 32'd0);
        send(1'b0, 8'h44);
        check("f1_valid", 32'(out_valid), 32'd1);
        check("f1_data", out_data, 32'h44332211);
        check("f1_sync", 32'(sync_err), 32'd0);
        tick();
        check("f1_taken", 32'(out_valid), 32'd0);

        // Words without sof after reset are ignored
        rst = 1'b1; tick(); rst = 1'b0;
        send(1'b0, 8'h55);
        check("hunt_sync", 32'(sync_err), 32'd0);
        send(1'b0, 8'h66);
        send(1'b1, 8'h01); send(1'b0, 8'h02); send(1'b0, 8'h03); send(1'b0, 8'h04);
        check("f2_valid", 32'(out_valid), 32'd1);
        check("f2_data", out_data, 32'h04030201);
        tick();

        // Early sof restarts the frame
        send(1'b1, 8'hA1); send(1'b0, 8'hA2);
        send(1'b1, 8'hB1);
        check("early_sof_err", 32'(sync_err), 32'd1);
        send(1'b0, 8'hB2);
        check("early_sof_pulse", 32'(sync_err), 32'd0);
        send(1'b0, 8'hB3); send(1'b0, 8'hB4);
        check("f3_valid", 32'(out_valid), 32'd1);
        check("f3_data", out_data, 32'hB4B3B2B1);
        tick();
        check("f3_taken", 32'(out_valid), 32'd0);

        // Backpressure: second frame dropped with ovf
        out_ready = 1'b0;
        send(1'b1, 8'hC1); send(1'b0, 8'hC2); send(1'b0, 8'hC3); send(1'b0, 8'hC4);
        check("f4_data", out_data, 32'hC4C3C2C1);
        send(1'b1, 8'hD1); send(1'b0, 8'hD2); send(1'b0, 8'hD3);
        check("hold_data", out_data, 32'hC4C3C2C1);
        check("hold_ovf", 32'(ovf), 32'd0);
        send(1'b0, 8'hD4);
        check("ovf_pulse", 32'(ovf), 32'd1);
        check("ovf_keep_data", out_data, 32'hC4C3C2C1);
        check("ovf_keep_valid", 32'(out_valid), 32'd1);
        tick();
        check("ovf_one_cycle", 32'(ovf), 32'd0);
`ifdef TDM_DEMUX_ERR_CNT_EN
        check("cnt_two", 32'(err_cnt), 32'd2);
`endif
        out_ready = 1'b1;
        tick();
        check("f4_taken", 32'(out_valid), 32'd0);

        // Gaps then reset mid-frame
        send(1'b1, 8'hE1); tick(); send(1'b0, 8'hE2); tick(); tick(); send(1'b0, 8'hE3);
        rst = 1'b1; tick(); rst = 1'b0;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_data", out_data, 32'h0);
`ifdef TDM_DEMUX_ERR_CNT_EN
        check("cnt_rst", 32'(err_cnt), 32'd0);
`endif
        send(1'b0, 8'hE4);
        check("midrst_noout", 32'(out_valid), 32'd0);
        send(1'b1, 8'hF1); tick(); send(1'b0, 8'hF2); send(1'b0, 8'hF3); tick(); send(1'b0, 8'hF4);
        check("f5_valid", 32'(out_valid), 32'd1);
        check("f5_data", out_data, 32'hF4F3F2F1);
        tick();

        // Missing sof after a complete frame drops to HUNT
        send(1'b0, 8'h77);
        check("nosof_err", 32'(sync_err), 32'd1);
        send(1'b0, 8'h88);
        check("hunt_quiet", 32'(sync_err), 32'd0);
`ifdef TDM_DEMUX_ERR_CNT_EN
        check("cnt_one", 32'(err_cnt), 32'd1);
`endif
        send(1'b1, 8'h91); send(1'b0, 8'h92); send(1'b0, 8'h93); send(1'b0, 8'h94);
        check("f6_data", out_data, 32'h94939291);
        check("f6_valid", 32'(out_valid), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
